// File: rtl/mc_sequencer_if.sv
// Bus bundle between the multi-cycle sequencer and its fetch/decode/memory environment.
// master = sequencer side, slave = environment side.
interface mc_sequencer_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 32
);
  logic              hold;
  logic              imem_req;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              is_load;
  logic              is_store;
  logic              rfwr_in;
  logic [4:0]        wnum_in;
  logic [XLEN-1:0]   wdata_in;
  logic [ADDR_W-1:0] npc_in;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [XLEN-1:0]   ir;
  logic [2:0]        state;
  logic              rf_we;
  logic [ADDR_W-1:0] debug_wb_pc;
  logic              debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [XLEN-1:0]   debug_wb_rf_wdata;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  hold, imem_ack, imem_rdata, dmem_ack,
           is_load, is_store, rfwr_in, wnum_in, wdata_in, npc_in,
    output imem_req, dmem_req, dmem_we, pc, pc_plus4, ir, state, rf_we,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, retired
  );

  modport slave (
    output hold, imem_ack, imem_rdata, dmem_ack,
           is_load, is_store, rfwr_in, wnum_in, wdata_in, npc_in,
    input  imem_req, dmem_req, dmem_we, pc, pc_plus4, ir, state, rf_we,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, retired
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// owning pc, ir, the retire counter and the writeback debug trace.
module mc_sequencer #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input logic           clk,
  input logic           rst,
  mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] PC_RST = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [ADDR_W-1:0] dbg_pc_q, dbg_pc_d;
  logic [4:0]        dbg_wnum_q, dbg_wnum_d;
  logic [XLEN-1:0]   dbg_wdata_q, dbg_wdata_d;
  logic              dbg_wen_q, dbg_wen_d;
  logic              imem_req_c, dmem_req_c, dmem_we_c, rf_we_c;
  logic              unused_npc_lsb;

  assign unused_npc_lsb = ^bus.npc_in[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pend_q      <= 1'b0;
      pc_q        <= PC_RST;
      ir_q        <= '0;
      ret_q       <= '0;
      dbg_pc_q    <= '0;
      dbg_wnum_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ret_q       <= ret_d;
      dbg_pc_q    <= dbg_pc_d;
      dbg_wnum_q  <= dbg_wnum_d;
      dbg_wdata_q <= dbg_wdata_d;
      dbg_wen_q   <= dbg_wen_d;
    end
  end

  // Next state and handshake strobes; a fetch request, once raised, is held
  // through hold until acked.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ret_d       = ret_q;
    dbg_pc_d    = dbg_pc_q;
    dbg_wnum_d  = dbg_wnum_q;
    dbg_wdata_d = dbg_wdata_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    rf_we_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = rst & (~bus.hold | pend_q);
        if (imem_req_c && bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pend_d  = 1'b0;
          state_d = S_DECODE;
        end else begin
          pend_d = imem_req_c;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (bus.is_load || bus.is_store) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = bus.is_store;
        if (bus.dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        rf_we_c     = bus.rfwr_in;
        pc_d        = {bus.npc_in[ADDR_W-1:2], 2'b00};
        ret_d       = ret_q + CNT_W'(1);
        dbg_pc_d    = pc_q;
        dbg_wnum_d  = bus.wnum_in;
        dbg_wdata_d = bus.wdata_in;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    dbg_wen_d = rf_we_c;
  end

  assign bus.imem_req          = imem_req_c;
  assign bus.dmem_req          = dmem_req_c;
  assign bus.dmem_we           = dmem_we_c;
  assign bus.rf_we             = rf_we_c;
  assign bus.pc                = pc_q;
  assign bus.pc_plus4          = pc_q + ADDR_W'(4);
  assign bus.ir                = ir_q;
  assign bus.state             = state_q;
  assign bus.retired           = ret_q;
  assign bus.debug_wb_pc       = dbg_pc_q;
  assign bus.debug_wb_rf_wen   = dbg_wen_q;
  assign bus.debug_wb_rf_wnum  = dbg_wnum_q;
  assign bus.debug_wb_rf_wdata = dbg_wdata_q;

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: instruction and data width.
REQ-002 SHALL have parameter ADDR_W, default 16: PC width in bytes; bits [1:0] always 0.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-004 SHALL have parameter CNT_W, default 32: retired-instruction counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port hold, input, 1: suppresses issuing a new fetch.
REQ-008 SHALL have ports imem_req (output, 1), imem_ack (input, 1) and imem_rdata (input, XLEN): instruction fetch handshake.
REQ-009 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1): data access handshake.
REQ-010 SHALL have decoder inputs is_load, is_store and rfwr_in (each 1), wnum_in (5) and wdata_in (XLEN), plus next-PC input npc_in (ADDR_W).
REQ-011 SHALL have outputs pc (ADDR_W), pc_plus4 (ADDR_W), ir (XLEN), state (3) and rf_we (1).
REQ-012 SHALL have debug outputs debug_wb_pc (ADDR_W), debug_wb_rf_wen (1), debug_wb_rf_wnum (5), debug_wb_rf_wdata (XLEN) and retired (CNT_W).

Function
REQ-013 SHALL implement the state machine FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-014 In FETCH with hold=0, imem_req SHALL be 1; with hold=1 and no request outstanding, imem_req SHALL be 0 and the state SHALL remain FETCH.
REQ-015 Once imem_req is raised it SHALL stay 1 until imem_ack, regardless of hold.
REQ-016 On imem_ack while imem_req=1: ir SHALL load imem_rdata, imem_req SHALL drop on the same edge, and the next state SHALL be DECODE.
REQ-017 imem_ack while imem_req=0 SHALL be ignored, with no change to ir or state.
REQ-018 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-019 EXEC SHALL last exactly one cycle; next state SHALL be MEM if is_load|is_store, otherwise WB.
REQ-020 In MEM: dmem_req SHALL be 1 and dmem_we SHALL equal is_store until dmem_ack; on dmem_ack the next state SHALL be WB.
REQ-021 dmem_we SHALL be 0 in every state other than MEM.
REQ-022 If is_load and is_store are both 1, the access SHALL be treated as a store (dmem_we=1).
REQ-023 In WB: rf_we SHALL equal rfwr_in combinationally for exactly one cycle, and rf_we SHALL be 0 in all other states.
REQ-024 On the WB edge, pc SHALL load {npc_in[ADDR_W-1:2],2'b00} and the next state SHALL be FETCH.
REQ-025 pc_plus4 SHALL equal pc+4 modulo 2^ADDR_W; for ADDR_W=16 and pc=0xFFFC, pc_plus4 SHALL be 0x0000.
REQ-026 retired SHALL increment by 1 on each WB edge and wrap from all-ones to 0.
REQ-027 On the WB edge, debug_wb_pc SHALL capture the retiring pc, debug_wb_rf_wnum SHALL capture wnum_in, and debug_wb_rf_wdata SHALL capture wdata_in.
REQ-028 debug_wb_rf_wen SHALL be a registered copy of rf_we, high for exactly the one cycle after WB; the other debug outputs SHALL hold their values until the next WB.
REQ-029 Minimum latency per instruction SHALL be 4 cycles without a memory access and 5 cycles with one, both with zero-wait acks; each wait cycle SHALL add 1.

Reset
REQ-030 While rst=0, regardless of clk: state=FETCH, pc=RESET_PC, ir=0 and retired=0.
REQ-031 While rst=0: imem_req, dmem_req, dmem_we, rf_we and debug_wb_rf_wen SHALL be 0, and debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata SHALL be 0.
REQ-032 Reset asserted mid-operation, including during an outstanding request, SHALL abort the instruction with no retire and no rf_we pulse.
REQ-033 A late ack arriving after reset SHALL be ignored per REQ-017.
REQ-034 After rst rises, the first imem_req SHALL assert in the first cycle with hold=0.

Verification
REQ-035 ALU instruction: reset, imem_ack=1 immediately with rdata 0x012A4020, rfwr_in=1, wnum_in=8, wdata_in=5, npc_in=4 -> states 0,1,2,4; rf_we for 1 cycle; next cycle debug_wb_pc=0, wnum=8, wdata=5, wen=1; pc=4; retired=1.
REQ-036 Load with 3 wait cycles on dmem_ack: is_load=1 -> dmem_req high for 4 cycles with dmem_we=0; the instruction retires 8 cycles after fetch start.
REQ-037 Store with is_load=is_store=1 -> dmem_we=1 throughout MEM; with rfwr_in=0, rf_we and debug_wb_rf_wen stay 0 while retired still increments.
REQ-038 hold=1 from reset for 10 cycles -> imem_req=0 and state=0 throughout; hold raised after imem_req asserts -> imem_req stays 1 until ack.
REQ-039 Wrap: ADDR_W=16, pc=0xFFFC, npc_in=0xFFFF -> pc_plus4=0x0000, next pc=0xFFFC; CNT_W=4 with 16 retires -> retired=0.
REQ-040 rst pulsed low during MEM -> all outputs reset immediately, retired unchanged at 0, and a late dmem_ack produces no effect.
